wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order pipeline writeback (W stage result) and a long-latency unit (multi-cycle mul/div) that returns results out of band.
- Long-latency results are buffered in a small FIFO. The pipeline wins by default.
- A starvation counter forces a queued write through by stalling W.
- Sits between the writeback stage/long-latency unit and the register file write port; drives the W-stall input of the hazard unit.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_result_fifo.sv | 82 ++++++++
 rtl/wb_port_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared writeback-port types: register address width, request record, grant source.
// WB_ARB_WAW_KILL_EN adds a per-entry valid bit to the request record.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
`ifdef WB_ARB_WAW_KILL_EN
    logic                  valid;
`endif
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LU
  } wb_gnt_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer for long-latency results with an occupancy count.
// WB_ARB_WAW_KILL_EN adds per-entry valid bits cleared by an rd-match kill port.
module wb_result_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [wb_pkg::REG_ADDR_W-1:0]  push_rd,
  input  logic [XLEN-1:0]                push_wd,
  input  logic                           pop,
`ifdef WB_ARB_WAW_KILL_EN
  input  logic                           kill_en,
  input  logic [wb_pkg::REG_ADDR_W-1:0]  kill_rd,
`endif
  output logic [wb_pkg::REG_ADDR_W-1:0]  head_rd,
  output logic [XLEN-1:0]                head_wd,
  output logic                           head_valid,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           empty,
  output logic                           full
);
  import wb_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [REG_ADDR_W-1:0] rd_mem [DEPTH];
  logic [XLEN-1:0]       wd_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        rd_mem[wr_ptr] <= push_rd;
        wd_mem[wr_ptr] <= push_wd;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef WB_ARB_WAW_KILL_EN
  logic [DEPTH-1:0] vld;

  // The push write comes last so an entry arriving with the killing rd survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (rd_mem[i] == kill_rd)) vld[i] <= 1'b0;
      end
      if (push) vld[wr_ptr] <= 1'b1;
    end
  end

  assign head_valid = vld[rd_ptr];
`else
  assign head_valid = 1'b1;
`endif

  assign head_rd = rd_mem[rd_ptr];
  assign head_wd = wd_mem[rd_ptr];
  assign count   = cnt;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued long-latency results.
// Optional WB_ARB_WAW_KILL_EN drops queued results overwritten by a later pipe write.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_regwrite,
  input  logic [4:0]               pipe_rd,
  input  logic [XLEN-1:0]          pipe_wd,
  input  logic                     lu_valid,
  input  logic [4:0]               lu_rd,
  input  logic [XLEN-1:0]          lu_wd,
  output logic                     lu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [XLEN-1:0]          rf_wd,
  output logic                     stall_w,
  output logic [$clog2(DEPTH):0]   lu_pending
);
  import wb_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic                  pipe_req;
  logic                  q_req;
  logic                  q_push;
  logic                  q_pop;
  logic                  q_skip;
  logic                  q_empty;
  logic                  q_full;
  logic                  q_head_valid;
  logic [REG_ADDR_W-1:0] q_head_rd;
  logic [XLEN-1:0]       q_head_wd;
  logic [SW-1:0]         starve_cnt;
  wb_gnt_e               gnt;

  wb_result_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_rd    (lu_rd),
    .push_wd    (lu_wd),
    .pop        (q_pop),
`ifdef WB_ARB_WAW_KILL_EN
    .kill_en    (gnt == GNT_PIPE),
    .kill_rd    (pipe_rd),
`endif
    .head_rd    (q_head_rd),
    .head_wd    (q_head_wd),
    .head_valid (q_head_valid),
    .count      (lu_pending),
    .empty      (q_empty),
    .full       (q_full)
  );

  // Writes to x0 never compete for the port.
  assign pipe_req = pipe_regwrite & (pipe_rd != '0);
  assign q_req    = ~q_empty & q_head_valid;

  // lu_ready comes from the registered count, so a full queue stays closed
  // even in the cycle it dequeues.
  assign lu_ready = ~rst & ~q_full;
  assign q_push   = lu_valid & lu_ready & (lu_rd != '0);

`ifdef WB_ARB_WAW_KILL_EN
  assign q_skip = ~q_empty & ~q_head_valid;
`else
  assign q_skip = 1'b0;
`endif
  assign q_pop = (gnt == GNT_LU) | q_skip;

  always_comb begin
    gnt     = GNT_NONE;
    stall_w = 1'b0;
    if (!rst) begin
      if (pipe_req && q_req && (starve_cnt == STARVE_TOP)) begin
        gnt     = GNT_LU;
        stall_w = 1'b1;
      end else if (pipe_req) begin
        gnt = GNT_PIPE;
      end else if (q_req) begin
        gnt = GNT_LU;
      end
    end
  end

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    case (gnt)
      GNT_PIPE: begin
        rf_we = 1'b1;
        rf_rd = pipe_rd;
        rf_wd = pipe_wd;
      end
      GNT_LU: begin
        rf_we = 1'b1;
        rf_rd = q_head_rd;
        rf_wd = q_head_wd;
      end
      default: ;
    endcase
  end

  // A skipped (killed) head neither resets nor advances the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (q_empty || (gnt == GNT_LU)) begin
      starve_cnt <= '0;
    end else if (q_req && (gnt == GNT_PIPE) && (starve_cnt < STARVE_TOP)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule
